stb_req_arbiter: RTL
====================

Name: stb_req_arbiter

Overview:
- Shares one strobe generator's request/valid handshake among N_REQ measurement clients (comparator samplers, DMA capture) using round-robin arbitration.
- Sequences the generator's req-edge / valid protocol so each client obtains exactly one fresh strobe-aligned window.
- Supervises the sequence with a period-scaled timeout.
- Sits between the strobe generator and the measurement-unit clients; one clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- T_CNT_WIDTH, 32, width of the strobe period input; fixed at 32.
- TIMEOUT_MARGIN, 64, extra cycles added to 2*period before a transaction is declared failed.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-client request; level; held until done_o or fail_o for that client.
- gnt_o  out  N_REQ  one-hot grant; high from grant until end of transaction.
- done_o  out  N_REQ  one-hot, 1-cycle pulse: fresh strobe window obtained.
- fail_o  out  N_REQ  one-hot, 1-cycle pulse: transaction aborted (timeout or generator error).
- busy_o  out  1  a transaction is in progress.
- gen_rdy_i  in  1  generator locked (period measured).
- gen_err_i  in  1  generator error.
- stb_period_i  in  T_CNT_WIDTH  measured strobe period in clk cycles.
- stb_req_o  out  1  strobe request to the generator; it acts on the rising edge.
- stb_valid_i  in  1  generator strobe-window valid.

Behaviour:
- Reset (async, arstn_i low): gnt_o=0, done_o=0, fail_o=0, busy_o=0, stb_req_o=0; state IDLE; round-robin pointer points at requester 0 (index 0 has highest priority first).
- All outputs are registered.
- States: IDLE, ARM, WAIT_DROP, WAIT_VALID, FINISH.
- IDLE:
  - stb_req_o=0.
  - If gen_rdy_i=1, gen_err_i=0 and req_i!=0: grant the first set bit at or after (last_grant+1) mod N_REQ.
  - Set gnt_o, latch limit = min(2*stb_period_i + TIMEOUT_MARGIN, 2^33-1) in a 33-bit register, clear the timeout counter, go to ARM.
  - If gen_rdy_i=0, requests wait; no fail.
- ARM: stb_req_o=1 for one cycle; go to WAIT_DROP.
- WAIT_DROP:
  - stb_req_o held 1.
  - Wait for stb_valid_i=0, which clears a stale valid left from the previous window, then go to WAIT_VALID.
- WAIT_VALID: stb_req_o held 1; on stb_valid_i=1, pulse done_o[g] and go to FINISH.
- FINISH:
  - stb_req_o=0, gnt_o=0; update last_grant=g; return to IDLE.
  - The next grant is therefore no earlier than 2 cycles later, guaranteeing stb_req_o is low at least 2 cycles between requests.
- Timeout counter:
  - 33 bits, increments in ARM/WAIT_DROP/WAIT_VALID, saturating.
  - When counter == limit: pulse fail_o[g] and go to FINISH.
- Generator error: gen_err_i=1 in any non-IDLE, non-FINISH state pulses fail_o[g] and goes to FINISH.
- Simultaneous events in the same cycle: err beats valid; timeout beats valid; done and fail never pulse together.
- Minimum latency: grant cycle to done_o is 4 cycles (ARM, 2 cycles generator edge-detect/clear in WAIT_DROP, then WAIT_VALID).
- If req_i[g] drops mid-transaction, the transaction still completes and done/fail still pulse; the client ignores it.
- busy_o=1 in every state except IDLE.
- Reset mid-transaction: immediate return to the reset values; stb_req_o falls asynchronously.

Decomposition:
- Package stb_arb_pkg holds:
  - state enum type (IDLE, ARM, WAIT_DROP, WAIT_VALID, FINISH);
  - localparams ARB_TO_WIDTH=33 and MIN_REQ_LOW_CYCLES=2.
- One sub-module, rr_arbiter #(N): combinational round-robin pick from req vector and last_grant, returning a one-hot grant and a valid flag.
- Timeout and FSM live in stb_req_arbiter.

Test Plan:
- Single client: gen_rdy_i=1, stb_period_i=100, req_i=0001, generator model drops valid 2 cycles after the req edge and raises it 10 cycles later -> gnt_o=0001 the next cycle, stb_req_o rises once, done_o[0] pulses exactly once; fail_o stays 0.
- Round-robin: req_i=1111 held, each transaction completed by the model -> grant order 0,1,2,3,0; stb_req_o low ≥2 cycles between rises; never two gnt_o bits high.
- Timeout: stb_period_i=10, TIMEOUT_MARGIN=64, model never raises valid -> fail_o[g] pulses exactly 84 cycles after entering ARM; the next requester is granted afterwards.
- Generator error: gen_err_i pulses in WAIT_VALID in the same cycle as a stb_valid_i rise -> fail_o pulses, done_o does not; return to IDLE.
- Not ready: gen_rdy_i=0 with req_i=0010 for 50 cycles -> no grant, stb_req_o=0; gen_rdy_i rises -> grant on the next cycle.
- Reset mid-WAIT_VALID: arstn_i low -> all outputs 0 immediately; after release with req_i=1000, the first grant goes to requester 3 (pointer at 0, scan 0..3).

Source files
------------

// File: rtl/stb_req_arbiter_pkg.sv
// Shared types and constants for the strobe-request arbiter.
package stb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_DROP,
        WAIT_VALID,
        FINISH
    } arb_state_e;

    localparam int ARB_TO_WIDTH       = 33;
    localparam int MIN_REQ_LOW_CYCLES = 2;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stb_req_arbiter_if.sv
// Client and generator handshake bundle between the arbiter and its neighbours.
interface stb_arb_if #(
    parameter int N_REQ       = 4,
    parameter int T_CNT_WIDTH = 32
);
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ-1:0]       gnt_o;
    logic [N_REQ-1:0]       done_o;
    logic [N_REQ-1:0]       fail_o;
    logic                   busy_o;
    logic                   gen_rdy_i;
    logic                   gen_err_i;
    logic [T_CNT_WIDTH-1:0] stb_period_i;
    logic                   stb_req_o;
    logic                   stb_valid_i;

    modport slave (
        input  req_i, gen_rdy_i, gen_err_i, stb_period_i, stb_valid_i,
        output gnt_o, done_o, fail_o, busy_o, stb_req_o
    );

    modport master (
        output req_i, gen_rdy_i, gen_err_i, stb_period_i, stb_valid_i,
        input  gnt_o, done_o, fail_o, busy_o, stb_req_o
    );
endinterface

// File: rtl/stb_req_arbiter_rr.sv
// Combinational round-robin pick: first request at or after last_grant+1, wrapping.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int LG_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [LG_W-1:0] last_grant,
    output logic [N-1:0]    gnt,
    output logic            valid
);

    logic [LG_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = LG_W'((int'(last_grant) + 1 + i) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stb_req_arbiter.sv
// Round-robin sharing of one strobe generator's req/valid handshake, with a
// period-scaled timeout supervising every transaction.
import stb_arb_pkg::*;

module stb_req_arbiter #(
    parameter int N_REQ          = 4,
    parameter int T_CNT_WIDTH    = 32,
    parameter int TIMEOUT_MARGIN = 64
) (
    input logic      clk_i,
    input logic      arstn_i,
    stb_arb_if.slave bus
);

    localparam int LG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LIM_W = ARB_TO_WIDTH + 1;

    arb_state_e              state, state_n;
    logic [N_REQ-1:0]        cur_gnt, cur_gnt_n, pick;
    logic                    pick_valid;
    logic [LG_W-1:0]         last_grant, last_grant_n;
    logic [ARB_TO_WIDTH-1:0] limit, limit_n, to_cnt, to_cnt_n, cnt_inc, limit_sat;
    logic [LIM_W-1:0]        limit_raw;
    logic [T_CNT_WIDTH-1:0]  period;
    logic [N_REQ-1:0]        gnt_q, done_q, fail_q, done_n, fail_n, gnt_n;
    logic                    busy_q, stb_req_q, busy_n, stb_req_n, active_n;

    rr_arbiter #(.N(N_REQ), .LG_W(LG_W)) u_rr (
        .req        (bus.req_i),
        .last_grant (last_grant),
        .gnt        (pick),
        .valid      (pick_valid)
    );

    // Limit is computed one bit wider so a huge period saturates instead of wrapping.
    assign period    = bus.stb_period_i;
    assign limit_raw = LIM_W'({period, 1'b0}) + LIM_W'(TIMEOUT_MARGIN);
    assign limit_sat = limit_raw[ARB_TO_WIDTH] ? {ARB_TO_WIDTH{1'b1}}
                                               : limit_raw[ARB_TO_WIDTH-1:0];
    assign cnt_inc   = (&to_cnt) ? to_cnt : to_cnt + ARB_TO_WIDTH'(1);

    always_comb begin
        state_n      = state;
        cur_gnt_n    = cur_gnt;
        last_grant_n = last_grant;
        limit_n      = limit;
        to_cnt_n     = to_cnt;
        done_n       = '0;
        fail_n       = '0;
        unique case (state)
            IDLE: begin
                if (bus.gen_rdy_i && !bus.gen_err_i && pick_valid) begin
                    cur_gnt_n = pick;
                    limit_n   = limit_sat;
                    to_cnt_n  = '0;
                    state_n   = ARM;
                end
            end
            ARM, WAIT_DROP, WAIT_VALID: begin
                // Error beats timeout, and both beat a coincident valid.
                to_cnt_n = cnt_inc;
                if (bus.gen_err_i || (cnt_inc == limit)) begin
                    fail_n  = cur_gnt;
                    state_n = FINISH;
                end else if (state == ARM) begin
                    state_n = WAIT_DROP;
                end else if (state == WAIT_DROP) begin
                    if (!bus.stb_valid_i) state_n = WAIT_VALID;
                end else if (bus.stb_valid_i) begin
                    done_n  = cur_gnt;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                last_grant_n = LG_W'(oh_to_idx(8'(cur_gnt)));
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        active_n  = (state_n == ARM) || (state_n == WAIT_DROP) || (state_n == WAIT_VALID);
        gnt_n     = active_n ? cur_gnt_n : '0;
        stb_req_n = active_n;
        busy_n    = (state_n != IDLE);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            cur_gnt    <= '0;
            last_grant <= LG_W'(N_REQ - 1);
            limit      <= '0;
            to_cnt     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            fail_q     <= '0;
            busy_q     <= 1'b0;
            stb_req_q  <= 1'b0;
        end else begin
            state      <= state_n;
            cur_gnt    <= cur_gnt_n;
            last_grant <= last_grant_n;
            limit      <= limit_n;
            to_cnt     <= to_cnt_n;
            gnt_q      <= gnt_n;
            done_q     <= done_n;
            fail_q     <= fail_n;
            busy_q     <= busy_n;
            stb_req_q  <= stb_req_n;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.fail_o    = fail_q;
    assign bus.busy_o    = busy_q;
    assign bus.stb_req_o = stb_req_q;

endmodule
